// File: rtl/dram_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : global_defs (package)
// Brief    : Shared types, address-map fields and default DRAM timings for
//            the DDR4 command scheduler.
// Revision : 1.0
// ============================================================================
package global_defs;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2
    } parsed_op_t;

    typedef enum logic [1:0] {
        PRE = 2'd0,
        ACT = 2'd1,
        RD  = 2'd2,
        WR  = 2'd3
    } dram_cmd_t;

    typedef logic [2:0] sched_state_t;
    localparam sched_state_t c_st_idle      = 3'd0;
    localparam sched_state_t c_st_pre       = 3'd1;
    localparam sched_state_t c_st_wait_rp   = 3'd2;
    localparam sched_state_t c_st_act       = 3'd3;
    localparam sched_state_t c_st_wait_rcd  = 3'd4;
    localparam sched_state_t c_st_rw        = 3'd5;
    localparam sched_state_t c_st_wait_data = 3'd6;
    localparam sched_state_t c_st_done      = 3'd7;

    localparam int c_bg_lsb     = 6;
    localparam int c_bg_msb     = 7;
    localparam int c_bank_lsb   = 8;
    localparam int c_bank_msb   = 9;
    localparam int c_col_lo_lsb = 3;
    localparam int c_col_lo_msb = 5;
    localparam int c_col_hi_lsb = 10;
    localparam int c_col_hi_msb = 17;
    localparam int c_row_lsb    = 18;
    localparam int c_row_msb    = 31;

    localparam int c_def_t_rp    = 24;
    localparam int c_def_t_rcd   = 24;
    localparam int c_def_t_cl    = 24;
    localparam int c_def_t_cwl   = 20;
    localparam int c_def_t_burst = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_scheduler_if
// Brief    : Parser-side request handshake and DRAM command output bundle.
// Revision : 1.0
// ============================================================================
interface dram_cmd_scheduler_if
    import global_defs::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int QUEUE_DEPTH   = 16
) ();

    logic                           op_ready_s;
    parsed_op_t                     opcode;
    logic [ADDRESS_WIDTH-1:0]       address;
    logic                           queue_full;
    logic [$clog2(QUEUE_DEPTH):0]   queue_count;
    logic                           cmd_valid;
    dram_cmd_t                      cmd;
    logic [1:0]                     cmd_bg;
    logic [1:0]                     cmd_bank;
    logic [13:0]                    cmd_row;
    logic [10:0]                    cmd_col;
    logic                           req_done;

    modport master (
        output op_ready_s, opcode, address,
        input  queue_full, queue_count, cmd_valid, cmd, cmd_bg, cmd_bank,
               cmd_row, cmd_col, req_done
    );

    modport slave (
        input  op_ready_s, opcode, address,
        output queue_full, queue_count, cmd_valid, cmd, cmd_bg, cmd_bank,
               cmd_row, cmd_col, req_done
    );

endinterface
`default_nettype wire

// File: rtl/dram_cmd_scheduler_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : req_queue
// Brief    : Power-of-two FIFO holding {opcode, address} requests.
// Revision : 1.0
// ============================================================================
module req_queue #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_scheduler
// Brief    : In-order open-page DDR4 PRE/ACT/RD/WR sequencer with request
//            queue. Define SCHED_TRACE_EN to print every issued command.
// Revision : 1.0
// ============================================================================
module dram_cmd_scheduler
    import global_defs::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int QUEUE_DEPTH   = 16,
    parameter int T_RP          = c_def_t_rp,
    parameter int T_RCD         = c_def_t_rcd,
    parameter int T_CL          = c_def_t_cl,
    parameter int T_CWL         = c_def_t_cwl,
    parameter int T_BURST       = c_def_t_burst
) (
    input  wire logic           clk,
    input  wire logic           rst,
    dram_cmd_scheduler_if.slave bus
);

    localparam int c_cnt_max = max2(max2(T_CL, T_CWL) + T_BURST, max2(T_RP, T_RCD));
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_qcnt_w  = $clog2(QUEUE_DEPTH) + 1;
    localparam int c_ent_w   = ADDRESS_WIDTH + 2;
    // Wait counters are loaded with T-2: one cycle for the wait state entry
    // and one for the registered command output.
    localparam logic [c_cnt_w-1:0] c_ld_rp  = c_cnt_w'(T_RP - 2);
    localparam logic [c_cnt_w-1:0] c_ld_rcd = c_cnt_w'(T_RCD - 2);
    localparam logic [c_cnt_w-1:0] c_ld_rd  = c_cnt_w'(T_CL + T_BURST - 2);
    localparam logic [c_cnt_w-1:0] c_ld_wr  = c_cnt_w'(T_CWL + T_BURST - 2);

    logic                     w_push, w_pop, w_full, w_empty;
    logic [c_ent_w-1:0]       w_push_data, w_head;
    logic [c_qcnt_w-1:0]      w_count;
    logic [ADDRESS_WIDTH-1:0] w_head_addr;
    logic                     w_head_wr;
    logic [3:0]               w_head_idx;
    logic [13:0]              w_head_row;
    logic [10:0]              w_head_col;
    logic                     w_unused_addr;

    sched_state_t             r_state, w_state_next;
    logic [c_cnt_w-1:0]       r_cnt, w_cnt_next;
    logic                     w_latch, w_bank_close, w_bank_open;
    logic                     w_cmd_valid_next, w_req_done_next;
    dram_cmd_t                w_cmd_next;

    logic [3:0]               r_cur_idx;
    logic [13:0]              r_cur_row;
    logic [10:0]              r_cur_col;
    logic                     r_cur_wr;
    logic [15:0]              r_bank_open;
    logic [15:0][13:0]        r_bank_row;

    logic                     r_cmd_valid, r_req_done;
    dram_cmd_t                r_cmd;
    logic [1:0]               r_cmd_bg, r_cmd_bank;
    logic [13:0]              r_cmd_row;
    logic [10:0]              r_cmd_col;

    assign w_push      = bus.op_ready_s && !w_full;
    assign w_push_data = {bus.opcode, bus.address};

    req_queue #(
        .WIDTH (c_ent_w),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_head_addr   = w_head[ADDRESS_WIDTH-1:0];
    assign w_head_wr     = (w_head[c_ent_w-1 -: 2] == WRITE);
    assign w_head_idx    = {w_head_addr[c_bg_msb:c_bg_lsb], w_head_addr[c_bank_msb:c_bank_lsb]};
    assign w_head_row    = w_head_addr[c_row_msb:c_row_lsb];
    assign w_head_col    = {w_head_addr[c_col_hi_msb:c_col_hi_lsb], w_head_addr[c_col_lo_msb:c_col_lo_lsb]};
    assign w_unused_addr = ^w_head_addr[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_latch          = 1'b0;
        w_bank_close     = 1'b0;
        w_bank_open      = 1'b0;
        w_cmd_valid_next = 1'b0;
        w_cmd_next       = r_cmd;
        w_req_done_next  = 1'b0;
        w_pop            = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_latch = 1'b1;
                    if (!r_bank_open[w_head_idx])
                        w_state_next = c_st_act;
                    else if (r_bank_row[w_head_idx] == w_head_row)
                        w_state_next = c_st_rw;
                    else
                        w_state_next = c_st_pre;
                end
            end
            c_st_pre: begin
                w_cmd_valid_next = 1'b1;
                w_cmd_next       = PRE;
                w_bank_close     = 1'b1;
                w_cnt_next       = c_ld_rp;
                w_state_next     = c_st_wait_rp;
            end
            c_st_wait_rp: begin
                if (r_cnt == '0) w_state_next = c_st_act;
                else             w_cnt_next   = r_cnt - c_cnt_w'(1);
            end
            c_st_act: begin
                w_cmd_valid_next = 1'b1;
                w_cmd_next       = ACT;
                w_bank_open      = 1'b1;
                w_cnt_next       = c_ld_rcd;
                w_state_next     = c_st_wait_rcd;
            end
            c_st_wait_rcd: begin
                if (r_cnt == '0) w_state_next = c_st_rw;
                else             w_cnt_next   = r_cnt - c_cnt_w'(1);
            end
            c_st_rw: begin
                w_cmd_valid_next = 1'b1;
                w_cmd_next       = r_cur_wr ? WR : RD;
                w_cnt_next       = r_cur_wr ? c_ld_wr : c_ld_rd;
                w_state_next     = c_st_wait_data;
            end
            c_st_wait_data: begin
                if (r_cnt == '0) w_state_next = c_st_done;
                else             w_cnt_next   = r_cnt - c_cnt_w'(1);
            end
            c_st_done: begin
                w_req_done_next = 1'b1;
                w_pop           = 1'b1;
                w_state_next    = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_idx   <= '0;
            r_cur_row   <= '0;
            r_cur_col   <= '0;
            r_cur_wr    <= 1'b0;
            r_bank_open <= '0;
            r_bank_row  <= '0;
        end else begin
            if (w_latch) begin
                r_cur_idx <= w_head_idx;
                r_cur_row <= w_head_row;
                r_cur_col <= w_head_col;
                r_cur_wr  <= w_head_wr;
            end
            if (w_bank_close) r_bank_open[r_cur_idx] <= 1'b0;
            if (w_bank_open) begin
                r_bank_open[r_cur_idx] <= 1'b1;
                r_bank_row[r_cur_idx]  <= r_cur_row;
            end
        end
    end

    // Command fields only change with a strobe so they hold between commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_req_done  <= 1'b0;
            r_cmd       <= PRE;
            r_cmd_bg    <= '0;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
        end else begin
            r_cmd_valid <= w_cmd_valid_next;
            r_req_done  <= w_req_done_next;
            if (w_cmd_valid_next) begin
                r_cmd      <= w_cmd_next;
                r_cmd_bg   <= r_cur_idx[3:2];
                r_cmd_bank <= r_cur_idx[1:0];
                if (w_cmd_next == ACT)                     r_cmd_row <= r_cur_row;
                if ((w_cmd_next == RD) || (w_cmd_next == WR)) r_cmd_col <= r_cur_col;
            end
        end
    end

    assign bus.queue_full  = w_full;
    assign bus.queue_count = w_count;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd         = r_cmd;
    assign bus.cmd_bg      = r_cmd_bg;
    assign bus.cmd_bank    = r_cmd_bank;
    assign bus.cmd_row     = r_cmd_row;
    assign bus.cmd_col     = r_cmd_col;
    assign bus.req_done    = r_req_done;

`ifdef SCHED_TRACE_EN
    logic [63:0] r_cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cycle_cnt <= '0;
        else     r_cycle_cnt <= r_cycle_cnt + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (r_cmd_valid) begin
            if (r_cmd == ACT)
                $display("%0d %s bg=%0h bank=%0h row=%0h", r_cycle_cnt, r_cmd.name(),
                         r_cmd_bg, r_cmd_bank, r_cmd_row);
            else
                $display("%0d %s bg=%0h bank=%0h col=%0h", r_cycle_cnt, r_cmd.name(),
                         r_cmd_bg, r_cmd_bank, r_cmd_col);
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Sits between the trace parser and the DRAM command output of the memory-controller model. It accepts parsed memory operations (read, write, instruction fetch) into an in-order request queue. For each queue head it sequences DDR4 PRE/ACT/RD/WR commands under an open-page policy, tracking the open row of all 16 banks. It enforces tRP, tRCD, tCL/tCWL and tBURST spacing with cycle counters and applies backpressure to the parser when the queue is full.

## Interface
- ADDRESS_WIDTH, 32, request address width
- QUEUE_DEPTH, 16, request queue entries (power of two)
- T_RP, 24, PRE to ACT, cycles
- T_RCD, 24, ACT to RD/WR, cycles
- T_CL, 24, RD to data start, cycles
- T_CWL, 20, WR to data start, cycles
- T_BURST, 4, data burst length, cycles

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- op_ready_s  in  1  parser has a valid operation this cycle
- opcode  in  parsed_op_t  READ / WRITE / IFETCH
- address  in  ADDRESS_WIDTH  byte address
- queue_full  out  1  request rejected this cycle if op_ready_s is high
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy
- cmd_valid  out  1  one-cycle command strobe
- cmd  out  dram_cmd_t  PRE / ACT / RD / WR
- cmd_bg  out  2  bank group
- cmd_bank  out  2  bank
- cmd_row  out  14  row (valid for ACT)
- cmd_col  out  11  column (valid for RD/WR)
- req_done  out  1  one-cycle pulse when the head request completes

## Operation
- Address map: bg=addr[7:6], bank=addr[9:8], col={addr[17:10],addr[5:3]}, row=addr[31:18]; addr[2:0] ignored.
- Accept when op_ready_s & !queue_full at a clk edge. The parser holds op and address until accepted.
- queue_full = (count==QUEUE_DEPTH), computed before the edge. A push while full is rejected even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves count unchanged.
- IFETCH is treated as READ.
- FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_DATA, DONE.
- IDLE: if the queue is non-empty, latch the head fields and branch:
  - row hit → RW
  - bank open, different row → PRE
  - bank closed → ACT
- PRE: cmd_valid, cmd=PRE; mark bank closed → WAIT_RP.
- ACT: cmd_valid, cmd=ACT; record open row → WAIT_RCD.
- RW: cmd_valid, cmd=RD or WR → WAIT_DATA.
- Wait states count down a counter loaded at command issue. Each exits so that the next cmd_valid falls exactly T cycles after the previous one:
  - WAIT_DATA uses T_CL+T_BURST for reads or T_CWL+T_BURST for writes.
- DONE: req_done for one cycle, pop the head → IDLE.
- Strictly in order, one request in flight. Outputs are registered; cmd fields hold their last value while cmd_valid is low.

## Timing
- Reset values:
  - queue empty, count 0, queue_full 0
  - cmd_valid 0, cmd=PRE encoding 0, all cmd fields 0
  - req_done 0, all banks closed, state IDLE
- Reset asserted mid-operation abandons the in-flight request: no req_done, queue cleared, all bank state closed.
- Accept at edge E puts the head in IDLE at E+1; the first cmd_valid is at E+2.
- Closed bank: ACT at C, RD/WR at C+T_RCD, req_done at RW+T_CL+T_BURST (read) or RW+T_CWL+T_BURST (write).
- Row miss adds PRE at C−T_RP before the ACT.
- Back-to-back hits: the next RW issues 2 cycles after req_done (DONE→IDLE→RW).
- No counter wraps: counter width is sized to hold max(T_CL,T_CWL)+T_BURST.

## Configuration
- SCHED_TRACE_EN defined: on every cmd_valid, $display the cycle count, command mnemonic, bg, bank, and row or col in hex. The cycle counter is a 64-bit free-running count cleared by rst.
- Undefined: no display and no cycle counter. Port behaviour is identical either way.

## Structure
- Package global_defs holds:
  - dram_cmd_t (PRE=0, ACT, RD, WR) and sched_state_t
  - address field LSB/MSB constants
  - default timing constants
  - parsed_op_t already lives there
- Sub-module req_queue: parameterised FIFO of {opcode, address} with push, pop, full, empty and count.

## Test plan
- rst held 2 cycles, then READ 0x0000_0000 → ACT bg0 bank0 row0; RD col0 24 cycles later; req_done 28 cycles after RD.
- READ 0x0000_0000 then READ 0x0000_0400 (same row, col 0x001<<3) → second request issues RD only, with no ACT.
- READ 0x0000_0000 then WRITE 0x0004_0000 (row 1, same bank) → PRE, ACT 24 cycles later, WR 24 cycles later; req_done at WR+24.
- 17 accepts attempted back-to-back while the scheduler is stalled on a first request → queue_full rises after the 16th accept; the 17th is held and accepted the cycle after the first req_done.
- IFETCH to bg1 bank2 (addr 0x0000_0240) → ACT with cmd_bg=1, cmd_bank=2, followed by RD.
- rst asserted during WAIT_RCD → all outputs 0 next cycle; a subsequent READ to the same row issues ACT, because the bank state was cleared.
